seg_scan_driver: RTL
====================

Name: seg_scan_driver

Overview:
- Parametrised multiplexed N-digit hex seven-segment display driver; next generation of the team's single-digit combinational hex decoder.
- Holds a double-buffered display value and scans the digits one at a time. Per-digit commons are time-multiplexed by a prescaled refresh counter.
- Adds anti-ghost guard time, leading-zero suppression, per-digit decimal points, selectable output polarity and tear-free frame-boundary updates.
- Sits between register/control logic and board segment/common pins.

Parameters:
DIGITS, 4, number of digits scanned (1..16)
PRESCALE, 10000, clock cycles per digit slot (must be >= GUARD+2)
GUARD, 2, cycles at the start of each slot with all commons inactive
SEG_ACTIVE_LOW, 0, 1 = seg/dp pins driven active-low
COM_ACTIVE_LOW, 1, 1 = com pins driven active-low

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
load  input  1  one-cycle strobe; captures value and dp_in
value  input  4*DIGITS  hex nibbles; nibble i (bits 4i+3:4i) is digit i, digit 0 rightmost
dp_in  input  DIGITS  decimal point per digit
blank_en  input  1  1 = leading-zero suppression enabled
seg  output  7  segments {a,b,c,d,e,f,g}, bit6 = a
dp  output  1  decimal point of the current digit
com  output  DIGITS  digit commons, one-hot active when lit
frame_start  output  1  one-cycle pulse at each frame wrap

Behaviour:
- One clock domain. Reset is asynchronous and active-low.
- Reset values:
  - Internal: cnt=0, idx=0, shadow value/dp=0, pending value/dp=0, pend_flag=0.
  - Outputs: com all inactive level; seg all-off level (7'b0000000 active-high, 7'b1111111 active-low); dp off level; frame_start=0.
  - Reset asserted mid-scan forces these values immediately, without waiting for a clock edge.
- Counters:
  - cnt counts 0..PRESCALE-1 and wraps.
  - On cnt==PRESCALE-1, idx increments, and wraps DIGITS-1 -> 0.
  - Widths: cnt = max(1,clog2(PRESCALE)); idx = max(1,clog2(DIGITS)).
- Buffering:
  - A load pulse writes value/dp_in into the pending buffer and sets pend_flag.
  - Multiple loads within one frame: the last one wins.
  - Wrap cycle (cnt==PRESCALE-1 and idx==DIGITS-1):
    - If pend_flag is set, shadow <= pending and pend_flag is cleared.
    - If load is asserted in that same cycle, the load data goes directly to shadow and pend_flag is cleared.
  - The displayed data changes only at frame boundaries, never mid-frame.
- Decode, per nibble, active-high segments:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1111011, A=1110111, b=0011111, c=0001101, d=0111101, E=1001111, F=1000111
- Leading-zero suppression:
  - When blank_en=1, digit i is blanked (seg and dp off) if every shadow nibble j>=i is 0 and every shadow dp j>=i is 0.
  - Digit 0 is never blanked.
  - With blank_en=0, no digit is ever blanked.
- Output registration, all outputs registered:
  - For the cycle after a clock edge, com/seg/dp reflect the cnt/idx held before that edge. Total latency from counter state to pins is 1 cycle.
  - com[idx] is active only when cnt >= GUARD; all other commons are always inactive.
  - seg/dp present digit idx for the whole slot, including the guard cycles.
  - So each slot gives PRESCALE-GUARD active cycles preceded by GUARD dark cycles.
- frame_start is high for exactly the one cycle in which the new shadow is first displayed, i.e. the first cycle of the digit-0 slot.
- Polarity: SEG_ACTIVE_LOW inverts seg and dp; COM_ACTIVE_LOW inverts com. Both are applied at the output registers.
- DIGITS=1: idx is constant 0 and every slot is a frame; frame_start pulses every PRESCALE cycles.

Test Plan:
- Bench defaults: DIGITS=4, PRESCALE=8, GUARD=2, COM_ACTIVE_LOW=1, SEG_ACTIVE_LOW=0.
- Reset: drive rst_n low mid-slot at idx=2 -> com=4'b1111 and seg=7'b0000000 with no clock edge; after release, digit 0 scans first and frame_start pulses every 32 cycles.
- Hex scan: load value=16'h12AF, blank_en=0 -> after the next frame_start, digits 0..3 show seg 1000111, 1110111, 1101101, 0110000 in turn. Each com is low for 6 cycles, then all commons are high for 2 cycles.
- Suppression: blank_en=1 with value=16'h0050 -> digits 3 and 2 dark, digit 1 = 1011011, digit 0 = 1111110. With value=16'h0000 -> only digit 0 lit, showing 1111110.
- Decimal point: value=16'h0005, dp_in=4'b0010, blank_en=1 -> digit 1 = 1111110 with dp=1, digits 3 and 2 dark, digit 0 = 1011011.
- Tear-free update:
  - Loads of 16'h1111 then 16'h2222 during idx=1 -> digits 2 and 3 of the current frame still show old data; 2222 appears at the next frame_start.
  - Load in the wrap cycle -> that data appears at the immediately following frame_start.
- Polarity: SEG_ACTIVE_LOW=1, COM_ACTIVE_LOW=0, value=16'h8888 -> seg=7'b0000000 while lit, com one-hot high, reset seg=7'b1111111.

Source files
------------

// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - multiplexed N-digit hex seven-segment scan driver
// Double-buffered value, guard-time blanking, leading-zero suppression, registered pins.
module seg_scan_driver #(
   parameter int DIGITS         = 4,
   parameter int PRESCALE       = 10000,
   parameter int GUARD          = 2,
   parameter int SEG_ACTIVE_LOW = 0,
   parameter int COM_ACTIVE_LOW = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   value,
   input  logic [DIGITS-1:0]     dp_in,
   input  logic                  blank_en,
   output logic [6:0]            seg,
   output logic                  dp,
   output logic [DIGITS-1:0]     com,
   output logic                  frame_start
);

   localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
   localparam logic [CW-1:0] GUARD_C  = CW'(GUARD);
   localparam logic          SEG_INV  = (SEG_ACTIVE_LOW != 0);
   localparam logic          COM_INV  = (COM_ACTIVE_LOW != 0);
   localparam logic [6:0]        SEG_OFF = SEG_INV ? 7'h7F : 7'h00;
   localparam logic [DIGITS-1:0] COM_OFF = COM_INV ? '1 : '0;

   logic [CW-1:0]         cnt_q, cnt_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [4*DIGITS-1:0]   shadow_val_q, shadow_val_d, pend_val_q, pend_val_d;
   logic [DIGITS-1:0]     shadow_dp_q, shadow_dp_d, pend_dp_q, pend_dp_d;
   logic                  pend_flag_q, pend_flag_d;
   logic [6:0]            seg_q, seg_d;
   logic                  dp_q, dp_d;
   logic [DIGITS-1:0]     com_q, com_d;
   logic                  fs_q, fs_d;

   logic                  slot_end, wrap;
   logic [3:0]            nib;
   logic                  nib_dp, tail_nz, blank;
   logic [6:0]            seg_raw;
   logic [DIGITS-1:0]     com_raw;

   function automatic logic [6:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: hex7 = 7'b1111110;
         4'h1: hex7 = 7'b0110000;
         4'h2: hex7 = 7'b1101101;
         4'h3: hex7 = 7'b1111001;
         4'h4: hex7 = 7'b0110011;
         4'h5: hex7 = 7'b1011011;
         4'h6: hex7 = 7'b1011111;
         4'h7: hex7 = 7'b1110000;
         4'h8: hex7 = 7'b1111111;
         4'h9: hex7 = 7'b1111011;
         4'hA: hex7 = 7'b1110111;
         4'hB: hex7 = 7'b0011111;
         4'hC: hex7 = 7'b0001101;
         4'hD: hex7 = 7'b0111101;
         4'hE: hex7 = 7'b1001111;
         default: hex7 = 7'b1000111;
      endcase
   endfunction

   always_comb begin
      slot_end     = (cnt_q == CNT_LAST);
      wrap         = slot_end && (idx_q == IDX_LAST);
      cnt_d        = slot_end ? '0 : cnt_q + CW'(1);
      idx_d        = idx_q;
      if (slot_end) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);

      shadow_val_d = shadow_val_q;
      shadow_dp_d  = shadow_dp_q;
      pend_val_d   = pend_val_q;
      pend_dp_d    = pend_dp_q;
      pend_flag_d  = pend_flag_q;
      // A load landing on the wrap cycle bypasses the pending buffer so it shows next frame.
      if (wrap) begin
         if (load) begin
            shadow_val_d = value;
            shadow_dp_d  = dp_in;
         end else if (pend_flag_q) begin
            shadow_val_d = pend_val_q;
            shadow_dp_d  = pend_dp_q;
         end
         pend_flag_d = 1'b0;
      end else if (load) begin
         pend_val_d  = value;
         pend_dp_d   = dp_in;
         pend_flag_d = 1'b1;
      end
   end

   always_comb begin
      nib     = 4'h0;
      nib_dp  = 1'b0;
      tail_nz = 1'b0;
      com_raw = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx_q == IW'(i)) begin
            nib    = shadow_val_q[4*i +: 4];
            nib_dp = shadow_dp_q[i];
            if (cnt_q >= GUARD_C) com_raw[i] = 1'b1;
         end
         // Any non-zero nibble or dp at or left of this digit keeps it lit.
         if ((IW'(i) >= idx_q) && ((shadow_val_q[4*i +: 4] != 4'h0) || shadow_dp_q[i]))
            tail_nz = 1'b1;
      end
      blank   = blank_en && (idx_q != '0) && !tail_nz;
      seg_raw = blank ? 7'h00 : hex7(nib);
      seg_d   = SEG_INV ? ~seg_raw : seg_raw;
      dp_d    = SEG_INV ? ~(nib_dp && !blank) : (nib_dp && !blank);
      com_d   = COM_INV ? ~com_raw : com_raw;
      fs_d    = (cnt_q == '0) && (idx_q == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q        <= '0;
         idx_q        <= '0;
         shadow_val_q <= '0;
         shadow_dp_q  <= '0;
         pend_val_q   <= '0;
         pend_dp_q    <= '0;
         pend_flag_q  <= 1'b0;
         seg_q        <= SEG_OFF;
         dp_q         <= SEG_INV;
         com_q        <= COM_OFF;
         fs_q         <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         shadow_val_q <= shadow_val_d;
         shadow_dp_q  <= shadow_dp_d;
         pend_val_q   <= pend_val_d;
         pend_dp_q    <= pend_dp_d;
         pend_flag_q  <= pend_flag_d;
         seg_q        <= seg_d;
         dp_q         <= dp_d;
         com_q        <= com_d;
         fs_q         <= fs_d;
      end
   end

   assign seg         = seg_q;
   assign dp          = dp_q;
   assign com         = com_q;
   assign frame_start = fs_q;

endmodule
